// File: rtl/rv_mem_resp.sv
// Single-ported word RAM shared by the core's instruction and data buses.
// Data port wins conflicts, but a served conflict hands the next slot to fetch.
module rv_mem_resp #(
  parameter int          AW   = 14,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          WS   = 0
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [31:0] i_adr,
  input  logic        i_re,
  output logic [31:0] i_dr,
  output logic        i_rdy,
  input  logic [31:0] d_adr,
  input  logic        d_re,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_dw,
  output logic [31:0] d_dr,
  output logic        d_rdy
);

  logic [31:0]   r_mem [0:(2**AW)-1];
  logic [31:0]   r_rd;
  logic [31:0]   r_idr;
  logic [1:0]    r_cnt;
  logic          r_iprio;
  logic          r_ipend;
  logic          r_dpend;

  logic          w_req_i;
  logic          w_req_d;
  logic          w_d_wr;
  logic          w_i_hit;
  logic          w_d_hit;
  logic [AW-1:0] w_i_idx;
  logic [AW-1:0] w_d_idx;
  logic          w_idle;
  logic          w_ready;
  logic          w_acc_i;
  logic          w_acc_d;
  logic          w_acc;
  logic          w_unused;

  assign w_req_i = i_re;
  assign w_d_wr  = |d_we;
  assign w_req_d = d_re | w_d_wr;
  assign w_i_hit = (i_adr[31:AW+2] == BASE[31:AW+2]);
  assign w_d_hit = (d_adr[31:AW+2] == BASE[31:AW+2]);
  assign w_i_idx = i_adr[AW+1:2];
  assign w_d_idx = d_adr[AW+1:2];
  assign w_unused = &{1'b0, i_adr[1:0], d_adr[1:0]};

  // The data-valid cycle is the first cycle with the wait counter back at zero.
  assign w_idle  = (r_cnt == 2'd0);
  assign w_ready = xreset & w_idle;
  assign d_rdy   = w_ready & ~(r_iprio & w_req_i);
  assign i_rdy   = w_ready & (r_iprio | ~w_req_d);
  assign w_acc_d = w_req_d & d_rdy;
  assign w_acc_i = w_req_i & i_rdy;
  assign w_acc   = w_acc_i | w_acc_d;

  assign d_dr = (r_dpend & w_idle) ? r_rd : 32'h0;
  assign i_dr = (r_ipend & w_idle) ? r_rd : r_idr;

  // Array access at the accepting edge; misses read as zero and never write.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (w_acc_d && w_d_hit && d_we[n]) begin
        r_mem[w_d_idx][8*n +: 8] <= d_dw[8*n +: 8];
      end
    end
    if (w_acc_i) begin
      r_rd <= w_i_hit ? r_mem[w_i_idx] : 32'h0;
    end else if (w_acc_d && !w_d_wr) begin
      r_rd <= w_d_hit ? r_mem[w_d_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_cnt   <= 2'd0;
      r_iprio <= 1'b0;
      r_ipend <= 1'b0;
      r_dpend <= 1'b0;
      r_idr   <= 32'h0;
    end else begin
      if (w_acc) begin
        r_cnt <= 2'(WS);
      end else if (!w_idle) begin
        r_cnt <= r_cnt - 2'd1;
      end

      // A data win over a waiting fetch owes the fetch the next slot.
      if (w_acc_d) begin
        r_iprio <= w_req_i;
      end else if (w_acc_i) begin
        r_iprio <= 1'b0;
      end

      if (w_acc) begin
        r_ipend <= w_acc_i;
        r_dpend <= w_acc_d & ~w_d_wr;
      end else if (w_idle) begin
        r_ipend <= 1'b0;
        r_dpend <= 1'b0;
      end

      if (r_ipend && w_idle) begin
        r_idr <= r_rd;
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_resp.sv
// Bench for rv_mem_resp: three instances (WS=0,2,3) share one stimulus stream
// and are each compared every cycle against a transaction-level model.
module tb_rv_mem_resp;

  logic        clk;
  logic        xreset;
  logic [31:0] i_adr;
  logic        i_re;
  logic [31:0] d_adr;
  logic        d_re;
  logic [3:0]  d_we;
  logic [31:0] d_dw;

  logic [31:0] ddr  [3];
  logic [31:0] idr  [3];
  logic        drdy [3];
  logic        irdy [3];

  int tests;
  int fails;

  rv_mem_resp #(.AW(14), .BASE(32'h0), .WS(0)) u_ws0 (
    .clk(clk), .xreset(xreset), .i_adr(i_adr), .i_re(i_re), .i_dr(idr[0]),
    .i_rdy(irdy[0]), .d_adr(d_adr), .d_re(d_re), .d_we(d_we), .d_dw(d_dw),
    .d_dr(ddr[0]), .d_rdy(drdy[0]));

  rv_mem_resp #(.AW(14), .BASE(32'h0), .WS(2)) u_ws2 (
    .clk(clk), .xreset(xreset), .i_adr(i_adr), .i_re(i_re), .i_dr(idr[1]),
    .i_rdy(irdy[1]), .d_adr(d_adr), .d_re(d_re), .d_we(d_we), .d_dw(d_dw),
    .d_dr(ddr[1]), .d_rdy(drdy[1]));

  rv_mem_resp #(.AW(14), .BASE(32'h0), .WS(3)) u_ws3 (
    .clk(clk), .xreset(xreset), .i_adr(i_adr), .i_re(i_re), .i_dr(idr[2]),
    .i_rdy(irdy[2]), .d_adr(d_adr), .d_re(d_re), .d_we(d_we), .d_dw(d_dw),
    .d_dr(ddr[2]), .d_rdy(drdy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, the cycle from which the RAM is free again,
  // the cycle a scheduled read result appears, and the last fetched word.
  int          ws_m   [3];
  int          nfree  [3];
  int          due    [3];
  logic        kind_i [3];
  logic        prio_m [3];
  logic [31:0] pdata  [3];
  logic [31:0] last_i [3];
  logic [31:0] mem_m  [3][64];
  int          t;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, t);
    end
  endtask

  function automatic logic [31:0] init_val(input int w);
    return {8'hC0, 8'(w), 16'h1234 ^ 16'(w)};
  endfunction

  task automatic step();
    logic        req_i, req_d, d_hit, i_hit, rdy, e_drdy, e_irdy, valid;
    logic [31:0] e_ddr, e_idr;
    int          dw, iw;
    @(negedge clk);
    req_i = i_re;
    req_d = d_re | (d_we != 4'h0);
    d_hit = (d_adr[31:16] == 16'h0);
    i_hit = (i_adr[31:16] == 16'h0);
    dw = int'(d_adr[7:2]);
    iw = int'(i_adr[7:2]);
    for (int k = 0; k < 3; k++) begin
      if (!xreset) begin
        nfree[k] = 0; due[k] = -1; prio_m[k] = 1'b0; last_i[k] = 32'h0;
      end
      rdy    = xreset && (t >= nfree[k]);
      e_drdy = rdy && !(prio_m[k] && req_i);
      e_irdy = rdy && (prio_m[k] || !req_d);
      valid  = (due[k] == t);
      e_ddr  = (valid && !kind_i[k]) ? pdata[k] : 32'h0;
      e_idr  = (valid && kind_i[k]) ? pdata[k] : last_i[k];
      chk($sformatf("d_rdy[ws%0d]", ws_m[k]), 32'(drdy[k]), 32'(e_drdy));
      chk($sformatf("i_rdy[ws%0d]", ws_m[k]), 32'(irdy[k]), 32'(e_irdy));
      chk($sformatf("d_dr[ws%0d]",  ws_m[k]), ddr[k], e_ddr);
      chk($sformatf("i_dr[ws%0d]",  ws_m[k]), idr[k], e_idr);
      if (xreset) begin
        if (valid && kind_i[k]) last_i[k] = pdata[k];
        if (e_drdy && req_d) begin
          nfree[k]  = t + 1 + ws_m[k];
          prio_m[k] = req_i;
          if (d_we != 4'h0) begin
            due[k] = -1;
            if (d_hit)
              for (int n = 0; n < 4; n++)
                if (d_we[n]) mem_m[k][dw][8*n +: 8] = d_dw[8*n +: 8];
          end else begin
            due[k]    = t + 1 + ws_m[k];
            kind_i[k] = 1'b0;
            pdata[k]  = d_hit ? mem_m[k][dw] : 32'h0;
          end
        end else if (e_irdy && req_i) begin
          nfree[k]  = t + 1 + ws_m[k];
          prio_m[k] = 1'b0;
          due[k]    = t + 1 + ws_m[k];
          kind_i[k] = 1'b1;
          pdata[k]  = i_hit ? mem_m[k][iw] : 32'h0;
        end
      end
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ire, input logic [31:0] ia, input logic dre,
                       input logic [3:0] we, input logic [31:0] da, input logic [31:0] dd);
    i_re = ire; i_adr = ia; d_re = dre; d_we = we; d_adr = da; d_dw = dd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tests = 0; fails = 0; t = 0;
    ws_m[0] = 0; ws_m[1] = 2; ws_m[2] = 3;
    for (int k = 0; k < 3; k++) begin
      nfree[k] = 0; due[k] = -1; kind_i[k] = 1'b0; prio_m[k] = 1'b0;
      pdata[k] = 32'h0; last_i[k] = 32'h0;
    end
    xreset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    idle(3);
    xreset = 1'b1;

    // Fill words 0..63; each write held long enough for every instance.
    for (int w = 0; w < 64; w++) begin
      drive(1'b0, 32'h0, 1'b0, 4'hF, 32'(w * 4), init_val(w));
      for (int r = 0; r < 4; r++) step();
    end
    idle(4);

    // Write then read back at WS=0.
    drive(1'b0, 32'h0, 1'b0, 4'hF, 32'h10, 32'h1234_5678); step();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
    #3 chk("rd_accept_rdy", 32'(drdy[0]), 32'h1);
    step();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #3 chk("rd_after_wr", ddr[0], 32'h1234_5678);
    step();
    #3 chk("d_dr_idle_zero", ddr[0], 32'h0);
    idle(4);

    // Single byte lane 2.
    drive(1'b0, 32'h0, 1'b0, 4'b0100, 32'h10, 32'h00AB_0000); step();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0); step();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #3 chk("byte_lane", ddr[0], 32'h12AB_5678);
    step();
    idle(4);

    // Conflict: fetch held, data request for three cycles.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h40, (c < 3), 4'h0, 32'h10, 32'h0);
      #3;
      chk($sformatf("conf_drdy%0d", c), 32'(drdy[0]), 32'((c % 2) == 0));
      chk($sformatf("conf_irdy%0d", c), 32'(irdy[0]), 32'((c % 2) == 1));
      chk($sformatf("conf_idr%0d", c), idr[0], (c >= 2) ? init_val(16) : 32'h0);
      step();
    end
    idle(4);

    // Miss write and read; word 0 untouched.
    drive(1'b0, 32'h0, 1'b0, 4'hF, 32'h0001_0000, 32'hDEAD_BEEF); step();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0001_0000, 32'h0); step();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
    #3 chk("miss_read", ddr[0], 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #3 chk("miss_word0", ddr[0], init_val(0));
    step();
    idle(4);

    // Fetch with WS=2 timing.
    drive(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #3 chk("ws2_irdy_acc", 32'(irdy[1]), 32'h1);
    step();
    drive(1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      #3;
      chk($sformatf("ws2_irdy_busy%0d", c), 32'(irdy[1]), 32'h0);
      chk($sformatf("ws2_drdy_busy%0d", c), 32'(drdy[1]), 32'h0);
      step();
    end
    #3;
    chk("ws2_irdy_valid", 32'(irdy[1]), 32'h1);
    chk("ws2_idr_valid", idr[1], init_val(0));
    step();
    #3 chk("ws2_irdy_next_busy", 32'(irdy[1]), 32'h0);
    step();
    idle(4);

    // Reset in the middle of a WS=3 read.
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0); step();
    idle(1);
    xreset = 1'b0;
    #1;
    chk("rst_drdy", 32'(drdy[2]), 32'h0);
    chk("rst_irdy", 32'(irdy[2]), 32'h0);
    chk("rst_ddr", ddr[2], 32'h0);
    chk("rst_idr", idr[2], 32'h0);
    idle(2);
    xreset = 1'b1;
    idle(6);
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0); step();
    idle(3);
    #3 chk("rst_persist", ddr[2], 32'h12AB_5678);
    step();
    idle(2);

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      int r;
      logic [31:0] ia, da;
      ia = (($urandom_range(0, 15) == 0) ? 32'h0001_0000 : 32'h0)
           | 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
      da = (($urandom_range(0, 15) == 0) ? 32'h0001_0000 : 32'h0)
           | 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 3)
        drive($urandom_range(0, 9) < 7, ia, 1'($urandom_range(0, 1)),
              4'($urandom_range(1, 15)), da, $urandom);
      else if (r < 7)
        drive($urandom_range(0, 9) < 7, ia, 1'b1, 4'h0, da, $urandom);
      else
        drive($urandom_range(0, 9) < 7, ia, 1'b0, 4'h0, da, $urandom);
      step();
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
